// File: rtl/bc_stage_id.sv
// Decode stage: catches fetched words in a small FIFO, decodes RV32I fields and immediates, hands off over valid/ready.
// Optional macro BC_ID_RV32M_EN makes the RV32M encodings (opcode 0110011, funct7 0000001) legal.
module bc_stage_id #(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SKID        = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_flush,
  input  logic                   i_instr_valid,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  output logic                   o_fetch_hold,
  output logic                   o_overflow,
  input  logic                   i_ex_ready,
  output logic                   o_id_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [6:0]             o_opcode,
  output logic [4:0]             o_rd,
  output logic [4:0]             o_rs1,
  output logic [4:0]             o_rs2,
  output logic [2:0]             o_funct3,
  output logic [6:0]             o_funct7,
  output logic [DATA_WIDTH-1:0]  o_imm,
  output logic                   o_illegal
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
  logic [INSTR_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic                   id_valid_q, id_valid_d;
  logic                   overflow_q, overflow_d;
  logic                   fetch_hold_q, fetch_hold_d;
  logic                   illegal_q, illegal_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0]  imm_q, imm_d;

  logic [PW-1:0]          count, count_next;
  logic                   empty, full, push, load, bypass, pop, wr_en;
  logic [INSTR_WIDTH-1:0] next_word;
  logic [31:0]            imm32;
  logic                   illegal_dec;

  // Queue bookkeeping: bypass when empty, otherwise pop the head into the output register.
  always_comb begin
    count      = wr_ptr_q - rd_ptr_q;
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push       = i_instr_valid & ~i_flush;
    load       = (~id_valid_q | i_ex_ready) & (push | ~empty);
    bypass     = load & empty;
    pop        = load & ~empty;
    wr_en      = push & ~bypass & ~full;
    next_word  = bypass ? i_instr : mem_q[rd_ptr_q[AW-1:0]];
    count_next = count + PW'(wr_en) - PW'(pop);
  end

  // Field decode of the word about to enter the output register.
  always_comb begin
    imm32       = '0;
    illegal_dec = 1'b0;
    unique case (next_word[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011:
        imm32 = {{20{next_word[31]}}, next_word[31:20]};
      7'b0100011:
        imm32 = {{20{next_word[31]}}, next_word[31:25], next_word[11:7]};
      7'b1100011:
        imm32 = {{19{next_word[31]}}, next_word[31], next_word[7], next_word[30:25],
                 next_word[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm32 = {next_word[31:12], 12'b0};
      7'b1101111:
        imm32 = {{11{next_word[31]}}, next_word[31], next_word[19:12], next_word[20],
                 next_word[30:21], 1'b0};
      7'b0110011: begin
        illegal_dec = 1'b1;
        if (next_word[31:25] == 7'b0000000)
          illegal_dec = 1'b0;
        else if ((next_word[31:25] == 7'b0100000) &&
                 ((next_word[14:12] == 3'b000) || (next_word[14:12] == 3'b101)))
          illegal_dec = 1'b0;
`ifdef BC_ID_RV32M_EN
        else if (next_word[31:25] == 7'b0000001)
          illegal_dec = 1'b0;
`endif
      end
      default: illegal_dec = 1'b1;
    endcase
  end

  // Next-state for storage, pointers and output register; flush overrides push and load.
  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    id_valid_d   = id_valid_q;
    overflow_d   = overflow_q;
    fetch_hold_d = fetch_hold_q;
    instr_d      = instr_q;
    imm_d        = imm_q;
    illegal_d    = illegal_q;
    if (i_flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      id_valid_d   = 1'b0;
      overflow_d   = 1'b0;
      fetch_hold_d = 1'b0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q[AW-1:0]] = i_instr;
        wr_ptr_d                = wr_ptr_q + PW'(1);
      end
      if (push && full)
        overflow_d = 1'b1;
      if (pop)
        rd_ptr_d = rd_ptr_q + PW'(1);
      if (load) begin
        id_valid_d = 1'b1;
        instr_d    = next_word;
        imm_d      = DATA_WIDTH'(imm32);
        illegal_d  = illegal_dec;
      end else if (i_ex_ready) begin
        id_valid_d = 1'b0;
      end
      fetch_hold_d = ((DEPTH - 32'(count_next)) <= SKID);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      id_valid_q   <= 1'b0;
      overflow_q   <= 1'b0;
      fetch_hold_q <= 1'b0;
      instr_q      <= '0;
      imm_q        <= '0;
      illegal_q    <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      id_valid_q   <= id_valid_d;
      overflow_q   <= overflow_d;
      fetch_hold_q <= fetch_hold_d;
      instr_q      <= instr_d;
      imm_q        <= imm_d;
      illegal_q    <= illegal_d;
    end
  end

  assign o_fetch_hold = fetch_hold_q;
  assign o_overflow   = overflow_q;
  assign o_id_valid   = id_valid_q;
  assign o_instr      = instr_q;
  assign o_opcode     = instr_q[6:0];
  assign o_rd         = instr_q[11:7];
  assign o_rs1        = instr_q[19:15];
  assign o_rs2        = instr_q[24:20];
  assign o_funct3     = instr_q[14:12];
  assign o_funct7     = instr_q[31:25];
  assign o_imm        = imm_q;
  assign o_illegal    = illegal_q;

endmodule

// File: tb/tb_bc_stage_id.sv
// Directed and randomized self-checking bench for bc_stage_id (DEPTH=4, SKID=2).
module tb_bc_stage_id;

  logic        clk = 1'b0;
  logic        rst_n, flush, valid, ready;
  logic [31:0] instr;
  logic        hold, overflow, id_valid, illegal;
  logic [31:0] o_instr, imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];

  bc_stage_id dut (
    .i_clk(clk), .i_rstn(rst_n), .i_flush(flush),
    .i_instr_valid(valid), .i_instr(instr),
    .o_fetch_hold(hold), .o_overflow(overflow),
    .i_ex_ready(ready), .o_id_valid(id_valid), .o_instr(o_instr),
    .o_opcode(opcode), .o_rd(rd), .o_rs1(rs1), .o_rs2(rs2),
    .o_funct3(funct3), .o_funct7(funct7), .o_imm(imm), .o_illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] w2 [6];
  logic [31:0] t3_in  [4] = '{32'hFE112E23, 32'hFE0008E3, 32'h800000EF, 32'h123450B7};
  logic [31:0] t3_imm [4] = '{32'hFFFFFFFC, 32'hFFFFFFF0, 32'hFFF00000, 32'h12345000};
  logic [31:0] t5_in  [6] = '{32'h02208033, 32'h0000007F, 32'h40000033,
                              32'h40001033, 32'h0000000F, 32'h00000073};
  logic        t5_ill [6];
  logic        t2_hold [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic        t2_ovf  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        t2_dhold[4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
`ifdef BC_ID_RV32M_EN
    t5_ill = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    t5_ill = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`endif
    for (int k = 0; k < 6; k++) w2[k] = 32'h00000093 | ((k + 1) << 20);

    rst_n = 1'b0; flush = 1'b0; valid = 1'b0; ready = 1'b0; instr = '0;
    #12;
    chk("rst_valid", id_valid, 0);
    chk("rst_hold", hold, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_instr", o_instr, 0);
    chk("rst_imm", imm, 0);
    rst_n = 1'b1;
    cyc();

    // single addi, one-cycle latency
    valid = 1'b1; instr = 32'h00500093; ready = 1'b1;
    cyc();
    valid = 1'b0;
    chk("t1_valid", id_valid, 1);
    chk("t1_rd", rd, 1);
    chk("t1_rs1", rs1, 0);
    chk("t1_imm", imm, 5);
    chk("t1_illegal", illegal, 0);
    chk("t1_opcode", opcode, 7'h13);
    cyc();
    chk("t1_drained", id_valid, 0);

    // back-pressure: one word in output, four in queue, sixth dropped
    ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      valid = 1'b1; instr = w2[k];
      cyc();
      chk("t2_head", o_instr, w2[0]);
      chk("t2_hold", hold, t2_hold[k]);
      chk("t2_ovf", overflow, t2_ovf[k]);
    end
    valid = 1'b0; ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      cyc();
      chk("t2_order", o_instr, w2[k]);
      chk("t2_dvalid", id_valid, 1);
      chk("t2_dhold", hold, t2_dhold[k-1]);
    end
    cyc();
    chk("t2_empty", id_valid, 0);
    chk("t2_ovf_sticky", overflow, 1);

    // immediate formats, streamed through bypass
    for (int k = 0; k < 4; k++) begin
      valid = 1'b1; instr = t3_in[k];
      cyc();
      chk("t3_instr", o_instr, t3_in[k]);
      chk("t3_imm", imm, t3_imm[k]);
      chk("t3_illegal", illegal, 0);
    end
    valid = 1'b0;
    cyc();

    // flush with queued work and a simultaneous incoming word
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid = 1'b1; instr = w2[k];
      cyc();
    end
    chk("t4_pre_valid", id_valid, 1);
    chk("t4_pre_ovf", overflow, 1);
    flush = 1'b1; instr = 32'hDEADBEEF;
    cyc();
    flush = 1'b0; valid = 1'b0;
    chk("t4_valid", id_valid, 0);
    chk("t4_ovf", overflow, 0);
    chk("t4_hold", hold, 0);
    ready = 1'b1;
    cyc();
    chk("t4_no_stale", id_valid, 0);
    valid = 1'b1; instr = 32'h00A00113;
    cyc();
    valid = 1'b0;
    chk("t4_fresh", o_instr, 32'h00A00113);
    cyc();

    // legality
    for (int k = 0; k < 6; k++) begin
      valid = 1'b1; instr = t5_in[k];
      cyc();
      chk("t5_valid", id_valid, 1);
      chk("t5_illegal", illegal, t5_ill[k]);
      chk("t5_imm", imm, (k == 1) ? 32'h0 : ((k >= 4) ? 32'h0 : 32'h0));
    end
    valid = 1'b0;
    cyc();
    chk("t5_idle", id_valid, 0);

    // random valid/ready against a reference FIFO, then drain
    for (int i = 0; i < 420; i++) begin
      ready = (i >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (id_valid && ready) begin
        if (exp_q.size() == 0) chk("t6_dup", 1, 0);
        else chk("t6_order", o_instr, exp_q.pop_front());
      end
      valid = (i < 400) && !hold && ($urandom_range(0, 1) == 1);
      instr = $urandom;
      if (valid) exp_q.push_back(instr);
      cyc();
    end
    valid = 1'b0;
    chk("t6_left", 32'(exp_q.size()), 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_idle", id_valid, 0);

    // async reset mid-stream
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid = 1'b1; instr = w2[k];
      cyc();
    end
    valid = 1'b0;
    chk("t6_pre_hold", hold, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", id_valid, 0);
    chk("t6_rst_hold", hold, 0);
    chk("t6_rst_instr", o_instr, 0);
    chk("t6_rst_imm", imm, 0);
    #2;
    rst_n = 1'b1;
    ready = 1'b1;
    cyc();
    cyc();
    chk("t6_rst_nosurv", id_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
